program_loader: RTL and testbench

Boot-time writer for the core's instruction memory. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to program memory at byte addresses 0, 4, 8, …, the same addressing the core's pc uses when it fetches. Holds the core in stall until a frame with a correct checksum completes, then releases it. It sits between the host byte link (UART receiver or testbench) and the program memory write port.

---
 rtl/loader_pkg.sv | 6 +
 rtl/program_loader_if.sv | 11 +
 rtl/program_loader_word_assembler.sv | 30 +++
 rtl/program_loader.sv | 93 +++++++++
 tb/tb_program_loader.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and constants for the program loader.
package loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE} state_t;
  localparam logic [7:0] LOADER_HEADER = 8'hA5;
  localparam int LANE_W = 2;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host byte stream plus program-memory write port.
interface program_loader_if #(parameter int ADDR_W = 32);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master(output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave(input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/program_loader_word_assembler.sv
// word_assembler: collects little-endian bytes into 32-bit words.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [LANE_W-1:0] byte_cnt;
  logic [2:0][7:0] lanes;
  // The top lane is never stored: the 4th byte completes the word combinationally.
  assign word_valid = en && (&byte_cnt);
  assign word = {din, lanes[2], lanes[1], lanes[0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      lanes <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (en) begin
      byte_cnt <= byte_cnt + 1'b1;
      for (int i = 0; i < 3; i++)
        if (byte_cnt == LANE_W'(i)) lanes[i] <= din;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte stream to instruction memory, holds core until a good checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus,
  output logic             core_hold,
  output logic             done,
  output logic             error
);
  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);
  state_t state;
  logic accept, word_valid;
  logic [31:0] word;
  logic [7:0] n_words, word_cnt, csum;
  assign accept = bus.in_valid && bus.in_ready;
  word_assembler u_asm (
    .clk,
    .rst_n,
    .clr(state == S_LEN),
    .en(accept && state == S_DATA),
    .din(bus.in_data),
    .word_valid,
    .word
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bus.in_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      core_hold <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      n_words <= '0;
      word_cnt <= '0;
      csum <= '0;
    end else begin
      bus.in_ready <= 1'b1;
      bus.mem_we <= 1'b0;
      error <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: state <= bus.in_data == LOADER_HEADER ? S_LEN : S_IDLE;
          S_LEN: begin
            if (bus.in_data == 8'd0 || {1'b0, bus.in_data} > MAX_N) begin
              error <= 1'b1;
              state <= S_IDLE;
            end else begin
              n_words <= bus.in_data;
              word_cnt <= '0;
              csum <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            csum <= csum ^ bus.in_data;
            if (word_valid) begin
              bus.mem_we <= 1'b1;
              bus.mem_addr <= ADDR_W'({word_cnt, 2'b00});
              bus.mem_wdata <= word;
              word_cnt <= word_cnt + 8'd1;
              if (word_cnt == n_words - 8'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (bus.in_data == csum) begin
              done <= 1'b1;
              core_hold <= 1'b0;
              state <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_DONE: begin
            if (bus.in_data == LOADER_HEADER) begin
              done <= 1'b0;
              core_hold <= 1'b1;
              state <= S_LEN;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed vector table plus hand sequences for the program loader.
module tb_program_loader;
  localparam int MAXW = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_hold, done, error;
  int checks = 0;
  int failures = 0;
  program_loader_if #(.ADDR_W(32)) bus();
  program_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .core_hold(core_hold),
    .done(done),
    .error(error)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic [7:0] d;
    logic hold;
    logic dn;
    logic err;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic v, input logic [7:0] d, input logic hold, input logic dn,
                     input logic err, input logic we = 1'b0, input logic [31:0] addr = '0,
                     input logic [31:0] wdata = '0);
    vec_t r;
    r.v = v; r.d = d; r.hold = hold; r.dn = dn; r.err = err; r.we = we; r.addr = addr; r.wdata = wdata;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic good_payload(input logic hold);
    row(1, 8'h78, hold, 0, 0); row(1, 8'h56, hold, 0, 0); row(1, 8'h34, hold, 0, 0);
    row(1, 8'h12, hold, 0, 0, 1, 32'd0, 32'h12345678);
    row(1, 8'hEF, hold, 0, 0); row(1, 8'hBE, hold, 0, 0); row(1, 8'hAD, hold, 0, 0);
    row(1, 8'hDE, hold, 0, 0, 1, 32'd4, 32'hDEADBEEF);
  endtask

  initial begin
    logic [7:0] x, b;
    logic [31:0] w;
    int nwr;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    // reset held while bytes are offered
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), {bus.in_ready, core_hold, bus.mem_we, done, error}, 5'b01000);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.in_ready, 1'b1);

    // garbage then good frame
    row(1, 8'h00, 1, 0, 0); row(1, 8'hFF, 1, 0, 0); row(1, 8'h13, 1, 0, 0);
    row(1, 8'hA5, 1, 0, 0); row(1, 8'h02, 1, 0, 0);
    good_payload(1);
    row(1, 8'h2A, 0, 1, 0);
    // reload with a bad checksum
    row(1, 8'h13, 0, 1, 0);
    row(1, 8'hA5, 1, 0, 0); row(1, 8'h02, 1, 0, 0);
    good_payload(1);
    row(1, 8'h88, 1, 0, 1);
    row(0, 8'h00, 1, 0, 0);
    // resend with gaps in in_valid
    row(1, 8'hA5, 1, 0, 0); row(1, 8'h02, 1, 0, 0);
    row(1, 8'h78, 1, 0, 0); row(0, 8'hA5, 1, 0, 0); row(1, 8'h56, 1, 0, 0);
    row(0, 8'h00, 1, 0, 0); row(1, 8'h34, 1, 0, 0);
    row(1, 8'h12, 1, 0, 0, 1, 32'd0, 32'h12345678);
    row(0, 8'h12, 1, 0, 0); row(1, 8'hEF, 1, 0, 0); row(1, 8'hBE, 1, 0, 0);
    row(0, 8'hFF, 1, 0, 0); row(1, 8'hAD, 1, 0, 0);
    row(1, 8'hDE, 1, 0, 0, 1, 32'd4, 32'hDEADBEEF);
    row(1, 8'h2A, 0, 1, 0);
    // single-word reload
    row(1, 8'hA5, 1, 0, 0); row(1, 8'h01, 1, 0, 0);
    row(1, 8'h44, 1, 0, 0); row(1, 8'h33, 1, 0, 0); row(1, 8'h22, 1, 0, 0);
    row(1, 8'h11, 1, 0, 0, 1, 32'd0, 32'h11223344);
    row(1, 8'h44, 0, 1, 0);
    // length bounds
    row(1, 8'hA5, 1, 0, 0); row(1, 8'h00, 1, 0, 1); row(0, 8'h00, 1, 0, 0);
    row(1, 8'hA5, 1, 0, 0); row(1, 8'(MAXW + 1), 1, 0, 1); row(0, 8'h00, 1, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d);
      check($sformatf("row%0d_ctl", i), {bus.mem_we, core_hold, done, error},
            {tbl[i].we, tbl[i].hold, tbl[i].dn, tbl[i].err});
      if (tbl[i].we) check($sformatf("row%0d_wr", i), {bus.mem_addr, bus.mem_wdata},
                           {tbl[i].addr, tbl[i].wdata});
    end

    // maximum-length frame
    step(1, 8'hA5);
    step(1, 8'(MAXW));
    x = 8'h00;
    nwr = 0;
    for (int k = 0; k < MAXW; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(4 * k + j);
        w[8*j +: 8] = b;
        x ^= b;
        step(1, b);
        if (bus.mem_we) nwr++;
      end
      check($sformatf("max_word%0d", k), {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {1'b1, 32'(4 * k), w});
    end
    check("max_writes", nwr, MAXW);
    step(1, x);
    check("max_done", {core_hold, done, error}, 3'b010);

    // reset in the middle of a payload
    step(1, 8'hA5);
    step(1, 8'h02);
    step(1, 8'h78);
    step(1, 8'h56);
    rst_n = 1'b0;
    #1;
    check("midreset_out", {bus.in_ready, core_hold, done, error, bus.mem_we}, 5'b01000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nwr = 0;
    foreach (tbl[i]) if (i >= 7 && i <= 13) begin
      step(1, tbl[i].d);
      if (bus.mem_we) nwr++;
    end
    step(1, 8'h2A);
    check("midreset_nowrite", nwr, 0);
    check("midreset_state", {core_hold, done, error}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
